// File: rtl/tx_crc_backoff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tx_crc_backoff                                                |
// | Purpose  : MAC transmit helper: byte-wide CRC-32 generator (MSB-first    |
// |            register, LSB-first data bits) and a truncated binary         |
// |            exponential backoff timer driven by a free-running LFSR.      |
// | Config   : BACKOFF_FAST_SIM_EN - when defined the backoff slot is one    |
// |            clock instead of SLOT_TIME clocks. CRC engine is unaffected.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tx_crc_backoff #(
  parameter POLYNOMIAL = 32'h04C11DB7,
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH = 32,
  parameter SEED = 32'hFFFFFFFF,
  parameter int SLOT_TIME = 64
) (
  input  logic                  reset,
  input  logic                  clock,
  input  logic                  crc_init,
  input  logic [DATA_WIDTH-1:0] crc_data,
  input  logic                  crc_data_enable,
  output logic [CRC_WIDTH-1:0]  crc_out,
  input  logic                  random_init,
  input  logic [3:0]            retry_count,
  output logic                  random_trigger
);

  localparam logic [CRC_WIDTH-1:0] c_poly = POLYNOMIAL[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] c_seed = SEED[CRC_WIDTH-1:0];
  localparam logic [15:0]          c_lfsr_seed = 16'hACE1;
`ifdef BACKOFF_FAST_SIM_EN
  localparam logic [15:0]          c_slot = 16'd1;
`else
  localparam logic [15:0]          c_slot = 16'(SLOT_TIME);
`endif

  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic                 crc_fb;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [15:0]          count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 trigger_q, trigger_d;
  logic [4:0]           retry_p1;
  logic [4:0]           backoff_k;
  logic [9:0]           backoff_mask;
  logic [9:0]           backoff_r;
  logic [15:0]          backoff_load;

  assign crc_out        = crc_q;
  assign random_trigger = trigger_q;

  // CRC next state: init wins, otherwise fold all data bits LSB first in one cycle
  always_comb begin
    crc_d  = crc_q;
    crc_fb = 1'b0;
    if (crc_init) begin
      crc_d = c_seed;
    end else if (crc_data_enable) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        crc_fb = crc_d[CRC_WIDTH-1] ^ crc_data[i];
        crc_d  = {crc_d[CRC_WIDTH-2:0], 1'b0} ^ (crc_fb ? c_poly : '0);
      end
    end
  end

  // Backoff window: k = min(retry+1, 10) low LFSR bits, scaled by the slot length
  always_comb begin
    retry_p1  = {1'b0, retry_count} + 5'd1;
    backoff_k = (retry_p1 > 5'd10) ? 5'd10 : retry_p1;
    for (int i = 0; i < 10; i++) begin
      backoff_mask[i] = (5'(i) < backoff_k);
    end
    backoff_r    = lfsr_q[9:0] & backoff_mask;
    backoff_load = {6'd0, backoff_r} * c_slot;
  end

  // Backoff next state: free-running LFSR, restartable countdown, one-cycle trigger
  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    count_d   = count_q;
    busy_d    = busy_q;
    trigger_d = 1'b0;
    if (random_init) begin
      count_d = backoff_load;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (count_q == 16'd0) begin
        trigger_d = 1'b1;
        busy_d    = 1'b0;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
  end

  // State registers; reset aborts any backoff in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_q     <= c_seed;
      lfsr_q    <= c_lfsr_seed;
      count_q   <= 16'd0;
      busy_q    <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      trigger_q <= trigger_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_crc_backoff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tx_crc_backoff                                             |
// | Purpose  : Directed self-checking bench for tx_crc_backoff.              |
// | Config   : honours BACKOFF_FAST_SIM_EN (slot length 1 instead of 64).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tx_crc_backoff;

`ifdef BACKOFF_FAST_SIM_EN
  localparam int SLOT = 1;
`else
  localparam int SLOT = 64;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        crc_init = 1'b0;
  logic [7:0]  crc_data = 8'd0;
  logic        crc_data_enable = 1'b0;
  logic [31:0] crc_out;
  logic        random_init = 1'b0;
  logic [3:0]  retry_count = 4'd0;
  logic        random_trigger;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_lfsr;
  logic [31:0] exp_crc;
  logic [31:0] rev;
  string       msg;

  tx_crc_backoff dut (
    .reset           (reset),
    .clock           (clock),
    .crc_init        (crc_init),
    .crc_data        (crc_data),
    .crc_data_enable (crc_data_enable),
    .crc_out         (crc_out),
    .random_init     (random_init),
    .retry_count     (retry_count),
    .random_trigger  (random_trigger)
  );

  always #5 clock = ~clock;

  // Reference LFSR tracking the DUT's free-running sequence
  always @(posedge clock or posedge reset) begin
    if (reset) model_lfsr <= 16'hACE1;
    else       model_lfsr <= {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return c;
  endfunction

  function automatic int exp_delay(input logic [15:0] l, input logic [3:0] rc);
    int          k;
    logic [9:0]  m;
    k = int'(rc) + 1;
    if (k > 10) k = 10;
    m = 10'((1 << k) - 1);
    return 1 + int'(l[9:0] & m) * SLOT;
  endfunction

  // Called just after a negedge: one byte goes in on the next posedge
  task automatic feed(input logic [7:0] b);
    crc_data = b;
    crc_data_enable = 1'b1;
    exp_crc = crc_ref(exp_crc, b);
    @(negedge clock);
    check($sformatf("crc_byte_%02h", b), crc_out, exp_crc);
  endtask

  // mode 0: lfsr[0]==1 ; mode 1: lfsr[9:0] in 0x200..0x20F
  task automatic wait_lfsr(input int mode);
    int  n;
    bit  ok;
    n = 0;
    ok = 0;
    while (!ok && n < 5000) begin
      if (mode == 0) ok = model_lfsr[0];
      else           ok = (model_lfsr[9:0] >= 10'h200) && (model_lfsr[9:0] <= 10'h20F);
      if (!ok) begin
        @(negedge clock);
        n++;
      end
    end
    if (!ok) check("wait_lfsr_timeout", 32'd0, 32'd1);
  endtask

  // Called just after a negedge; measures edges from init to the trigger
  task automatic run_backoff(input logic [3:0] rc, input int exp, input string tag);
    int n;
    bit got;
    random_init = 1'b1;
    retry_count = rc;
    @(posedge clock);
    #1 random_init = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < exp + 200) begin
      @(posedge clock);
      #1;
      n++;
      if (random_trigger) got = 1;
    end
    check({tag, "_delay"}, got ? 32'(n) : 32'hFFFFFFFF, 32'(exp));
    @(posedge clock);
    #1;
    check({tag, "_width"}, {31'd0, random_trigger}, 32'd0);
  endtask

  task automatic count_pulses(input int cycles, input int exp, input string tag);
    int p;
    p = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (random_trigger) p++;
    end
    check(tag, 32'(p), 32'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_crc", crc_out, 32'hFFFFFFFF);
    check("reset_trigger", {31'd0, random_trigger}, 32'd0);

    // First attempt right after reset: lfsr=ACE1, retry 0 -> r=1
    reset = 1'b0;
    run_backoff(4'd0, 1 + SLOT, "first");

    // CRC reference vector with a 5-cycle hold in the middle
    @(negedge clock);
    crc_init = 1'b1;
    @(negedge clock);
    crc_init = 1'b0;
    check("crc_init", crc_out, 32'hFFFFFFFF);
    exp_crc = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) feed(8'h31 + 8'(i));
    crc_data_enable = 1'b0;
    crc_data = 8'hEE;
    repeat (5) @(negedge clock);
    check("crc_hold", crc_out, exp_crc);
    for (int i = 4; i < 9; i++) feed(8'h31 + 8'(i));
    crc_data_enable = 1'b0;
    check("crc_check_vec", crc_out, 32'h9B63D02C);
    for (int i = 0; i < 32; i++) rev[i] = crc_out[31-i];
    check("crc_fcs", ~rev, 32'hCBF43926);

    // Init after a frame, then init and enable together
    crc_init = 1'b1;
    @(negedge clock);
    crc_init = 1'b0;
    check("crc_reinit", crc_out, 32'hFFFFFFFF);
    exp_crc = 32'hFFFFFFFF;
    feed(8'h31);
    crc_init = 1'b1;
    crc_data = 8'hA5;
    @(negedge clock);
    crc_init = 1'b0;
    crc_data_enable = 1'b0;
    check("crc_init_prio", crc_out, 32'hFFFFFFFF);

    // Restart at edge 10 of a backoff: only the restarted one fires
    wait_lfsr(0);
    random_init = 1'b1;
    retry_count = 4'd0;
    @(posedge clock);
    #1 random_init = 1'b0;
    count_pulses(9, (SLOT > 8) ? 0 : 1, "restart_early");
    @(negedge clock);
    run_backoff(4'd0, exp_delay(model_lfsr, 4'd0), "restart");
    count_pulses(3 * SLOT + 20, 0, "restart_single");

    // Reset in the middle of a backoff aborts it
    @(negedge clock);
    wait_lfsr(0);
    random_init = 1'b1;
    retry_count = 4'd0;
    crc_data = 8'h55;
    crc_data_enable = 1'b1;
    @(posedge clock);
    #1;
    random_init = 1'b0;
    crc_data_enable = 1'b0;
    repeat (19) @(posedge clock);
    @(negedge clock);
    check("pre_reset_crc", crc_out, crc_ref(32'hFFFFFFFF, 8'h55));
    reset = 1'b1;
    #1;
    check("mid_reset_crc", crc_out, 32'hFFFFFFFF);
    check("mid_reset_trigger", {31'd0, random_trigger}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    count_pulses(3 * SLOT + 20, 0, "reset_abort");

    // Truncation: retry 15 uses the full 10-bit mask, retry 2 only 3 bits
    @(negedge clock);
    wait_lfsr(1);
    run_backoff(4'd15, exp_delay(model_lfsr, 4'd15), "trunc15");
    @(negedge clock);
    run_backoff(4'd2, exp_delay(model_lfsr, 4'd2), "trunc2");

    msg = $sformatf("Result: errors=%0d of %0d checks", errors, checks);
    $display("%s", msg);
    $finish;
  end

endmodule
`default_nettype wire
